id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between decode (D) and execute (E) of a 5-stage RV32
// pipeline, together with the execute-side operand selection that hangs
// directly off that register.
//
// The register captures the decode-stage operands, specifiers and control
// bits on every rising clk edge. The hazard unit can hold it (StallE) or
// replace its contents with a bubble (FlushE). A 16-bit saturating counter
// records how many bubbles have been inserted since reset.
//
// Ports
//   clk, rst_n            : clock; synchronous active-low reset
//   StallE, FlushE        : hold / bubble requests from the hazard unit
//   RD1D, RD2D            : register-file read data from decode
//   PCD, ImmExtD          : decode PC and sign-extended immediate
//   Rs1D, Rs2D, RdD       : register specifiers
//   RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD : decode control bits
//   ResultSrcD, ALUControlD                       : decode control fields
//   ForwardAE, ForwardBE  : forwarding selects (00 reg, 01 WB, 10 MEM, 11 reg)
//   ALUResultM, ResultW   : values forwarded from MEM and WB
//   SrcAE, SrcBE          : ALU operands
//   WriteDataE            : store data (forwarded B, ignores ALUSrc)
//   PCE, ImmExtE          : registered PC and immediate
//   PCTargetE             : PCE + ImmExtE (branch / jump target)
//   Rs1E, Rs2E, RdE       : registered specifiers
//   RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUControlE : controls
//   ValidE                : 1 when the stage holds a real instruction
//   BubbleCount           : saturating number of flushes since reset
//
// Hold/bubble semantics: on each edge the priority is reset, then FlushE,
// then StallE, then a normal load. FlushE wins over StallE so that a stalled
// instruction can still be squashed. There is no valid/ready handshake; the
// hazard unit owns flow control through StallE/FlushE.
// -----------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] PCD,
  input  logic [31:0] ImmExtD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        JumpD,
  input  logic        BranchD,
  input  logic        ALUSrcD,
  input  logic [1:0]  ResultSrcD,
  input  logic [2:0]  ALUControlD,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ResultW,
  output logic [31:0] SrcAE,
  output logic [31:0] SrcBE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] WriteDataE,
  output logic [31:0] PCE,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCTargetE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ValidE,
  output logic [1:0]  ResultSrcE,
  output logic [15:0] BubbleCount
);

  localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

  // Stage register fields
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imm_ext_q, imm_ext_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_write_q, mem_write_d;
  logic        jump_q, jump_d;
  logic        branch_q, branch_d;
  logic        alu_src_q, alu_src_d;
  logic [1:0]  result_src_q, result_src_d;
  logic [2:0]  alu_control_q, alu_control_d;
  logic        valid_q, valid_d;

  // Bubble statistics
  logic [15:0] bubble_count_q, bubble_count_d;

  // Execute-side operand selection
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // ---------------------------------------------------------------------------
  // Next-state for the stage register: hold by default, bubble on flush,
  // load when not stalled.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd1_d         = rd1_q;
    rd2_d         = rd2_q;
    pc_d          = pc_q;
    imm_ext_d     = imm_ext_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    reg_write_d   = reg_write_q;
    mem_write_d   = mem_write_q;
    jump_d        = jump_q;
    branch_d      = branch_q;
    alu_src_d     = alu_src_q;
    result_src_d  = result_src_q;
    alu_control_d = alu_control_q;
    valid_d       = valid_q;

    if (FlushE) begin
      // A bubble is an all-zero instruction: add with no side effects,
      // destination x0, and marked invalid.
      rd1_d         = '0;
      rd2_d         = '0;
      pc_d          = '0;
      imm_ext_d     = '0;
      rs1_d         = '0;
      rs2_d         = '0;
      rd_d          = '0;
      reg_write_d   = 1'b0;
      mem_write_d   = 1'b0;
      jump_d        = 1'b0;
      branch_d      = 1'b0;
      alu_src_d     = 1'b0;
      result_src_d  = '0;
      alu_control_d = '0;
      valid_d       = 1'b0;
    end else if (!StallE) begin
      rd1_d         = RD1D;
      rd2_d         = RD2D;
      pc_d          = PCD;
      imm_ext_d     = ImmExtD;
      rs1_d         = Rs1D;
      rs2_d         = Rs2D;
      rd_d          = RdD;
      reg_write_d   = RegWriteD;
      mem_write_d   = MemWriteD;
      jump_d        = JumpD;
      branch_d      = BranchD;
      alu_src_d     = ALUSrcD;
      result_src_d  = ResultSrcD;
      // Any encoding, defined or not, is carried through untouched; decoding
      // is the ALU's job.
      alu_control_d = ALUControlD;
      valid_d       = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bubble counter: counts flush edges, sticks at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (FlushE && (bubble_count_q != BUBBLE_MAX)) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd1_q          <= '0;
      rd2_q          <= '0;
      pc_q           <= '0;
      imm_ext_q      <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      mem_write_q    <= 1'b0;
      jump_q         <= 1'b0;
      branch_q       <= 1'b0;
      alu_src_q      <= 1'b0;
      result_src_q   <= '0;
      alu_control_q  <= '0;
      valid_q        <= 1'b0;
      bubble_count_q <= '0;
    end else begin
      rd1_q          <= rd1_d;
      rd2_q          <= rd2_d;
      pc_q           <= pc_d;
      imm_ext_q      <= imm_ext_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      mem_write_q    <= mem_write_d;
      jump_q         <= jump_d;
      branch_q       <= branch_d;
      alu_src_q      <= alu_src_d;
      result_src_q   <= result_src_d;
      alu_control_q  <= alu_control_d;
      valid_q        <= valid_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding muxes. Select 11 is unused by the hazard unit and falls back
  // to the register value so a stray select cannot inject stale data.
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_a = rd1_q;
    case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALUResultM;
      default: fwd_a = rd1_q;
    endcase
  end

  always_comb begin
    fwd_b = rd2_q;
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = rd2_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign SrcAE       = fwd_a;
  assign SrcBE       = alu_src_q ? imm_ext_q : fwd_b;
  // Stores always need the register operand even when the ALU takes the
  // immediate for address generation.
  assign WriteDataE  = fwd_b;
  assign PCTargetE   = pc_q + imm_ext_q;

  assign ALUControlE = alu_control_q;
  assign PCE         = pc_q;
  assign ImmExtE     = imm_ext_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign RegWriteE   = reg_write_q;
  assign MemWriteE   = mem_write_q;
  assign JumpE       = jump_q;
  assign BranchE     = branch_q;
  assign ResultSrcE  = result_src_q;
  assign ValidE      = valid_q;
  assign BubbleCount = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. A behavioural model of the stage register
// is advanced at every edge; the expected output vector is pushed into a
// queue when stimulus is driven and popped/compared once the DUT output is
// valid. Spot checks against literal values cover the worked examples.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int OW = 217;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT signals
  logic        StallE, FlushE;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultM, ResultW;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, PCTargetE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [15:0] BubbleCount;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
    .WriteDataE(WriteDataE), .PCE(PCE), .ImmExtE(ImmExtE),
    .PCTargetE(PCTargetE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ValidE(ValidE), .ResultSrcE(ResultSrcE),
    .BubbleCount(BubbleCount)
  );

  logic [OW-1:0] act_vec;
  assign act_vec = {SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, PCTargetE,
                    ALUControlE, Rs1E, Rs2E, RdE,
                    RegWriteE, MemWriteE, JumpE, BranchE, ValidE, ResultSrcE};

  // Reference model of the stage register
  logic [31:0] m_rd1, m_rd2, m_pc, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_rw, m_mw, m_j, m_b, m_alusrc, m_v;
  logic [1:0]  m_rs;
  logic [2:0]  m_alu;
  logic [15:0] m_bc;

  // Scoreboard
  logic [OW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Model one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (!rst_n) begin
      {m_rd1, m_rd2, m_pc, m_imm} = '0;
      {m_rs1, m_rs2, m_rd} = '0;
      {m_rw, m_mw, m_j, m_b, m_alusrc, m_v} = '0;
      m_rs = '0; m_alu = '0; m_bc = '0;
    end else if (FlushE) begin
      {m_rd1, m_rd2, m_pc, m_imm} = '0;
      {m_rs1, m_rs2, m_rd} = '0;
      {m_rw, m_mw, m_j, m_b, m_alusrc, m_v} = '0;
      m_rs = '0; m_alu = '0;
      if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
    end else if (!StallE) begin
      m_rd1 = RD1D; m_rd2 = RD2D; m_pc = PCD; m_imm = ImmExtD;
      m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD;
      m_rw = RegWriteD; m_mw = MemWriteD; m_j = JumpD; m_b = BranchD;
      m_alusrc = ALUSrcD; m_rs = ResultSrcD; m_alu = ALUControlD; m_v = 1'b1;
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    logic [31:0] fa, fb;
    case (ForwardAE)
      2'b01:   fa = ResultW;
      2'b10:   fa = ALUResultM;
      default: fa = m_rd1;
    endcase
    case (ForwardBE)
      2'b01:   fb = ResultW;
      2'b10:   fb = ALUResultM;
      default: fb = m_rd2;
    endcase
    return {fa, (m_alusrc ? m_imm : fb), fb, m_pc, m_imm, m_pc + m_imm,
            m_alu, m_rs1, m_rs2, m_rd, m_rw, m_mw, m_j, m_b, m_v, m_rs};
  endfunction

  task automatic sb_check(input string tag);
    logic [OW-1:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h expected <empty queue>", tag, act_vec);
    end else begin
      e = exp_q.pop_front();
      assert (act_vec === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, act_vec, e);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic chk_all_zero(input string tag);
    n_total++;
    assert (act_vec === '0) n_pass++;
    else $error("FAIL %s: observed %h expected all zero", tag, act_vec);
  endtask

  // Clock edge with scoreboarded output check.
  task automatic step(input string tag);
    model_edge();
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  // Combinational check after changing only forwarding / M / W inputs.
  task automatic comb(input string tag);
    exp_q.push_back(exp_vec());
    #1;
    sb_check(tag);
  endtask

  task automatic drive_rand_d();
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; ImmExtD = $urandom;
    Rs1D = 5'($urandom_range(0, 31)); Rs2D = 5'($urandom_range(0, 31));
    RdD = 5'($urandom_range(0, 31));
    RegWriteD = 1'($urandom_range(0, 1)); MemWriteD = 1'($urandom_range(0, 1));
    JumpD = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
    ALUSrcD = 1'($urandom_range(0, 1)); ResultSrcD = 2'($urandom_range(0, 3));
    ALUControlD = 3'($urandom_range(0, 7));
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] bc_before;
    logic [31:0] held_pc;
    int guard;

    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    ALUResultM = '0; ResultW = '0;
    drive_rand_d();

    // Reset edge
    step("reset");
    chk_all_zero("reset_zero");
    chk32("reset_bc", {16'd0, BubbleCount}, 32'd0);

    // Basic load
    rst_n = 1'b1;
    drive_rand_d();
    RD1D = 32'd5; RD2D = 32'd7; ALUSrcD = 1'b0; ALUControlD = 3'b001;
    step("load");
    chk32("load_srca", SrcAE, 32'd5);
    chk32("load_srcb", SrcBE, 32'd7);
    chk32("load_aluctl", {29'd0, ALUControlE}, 32'd1);
    chk32("load_valid", {31'd0, ValidE}, 32'd1);

    // Forwarding, same cycle
    drive_rand_d();
    RD1D = 32'd1; RD2D = 32'd2; ALUSrcD = 1'b0;
    step("fwd_load");
    ALUResultM = 32'hAAAA0000; ResultW = 32'h0000BBBB;
    ForwardAE = 2'b10; ForwardBE = 2'b01;
    comb("fwd_a10_b01");
    chk32("fwd_srca_m", SrcAE, 32'hAAAA0000);
    chk32("fwd_srcb_w", SrcBE, 32'h0000BBBB);
    ForwardAE = 2'b11;
    comb("fwd_a11");
    chk32("fwd_srca_11", SrcAE, 32'd1);
    ForwardAE = 2'b01; ForwardBE = 2'b10;
    comb("fwd_a01_b10");
    ForwardBE = 2'b11;
    comb("fwd_b11");
    chk32("fwd_srcb_11", SrcBE, 32'd2);

    // Immediate operand and branch target wrap
    drive_rand_d();
    ALUSrcD = 1'b1; ImmExtD = 32'hFFFFFFFC; PCD = 32'h00000004;
    ForwardBE = 2'b10;
    step("imm_load");
    chk32("imm_srcb", SrcBE, 32'hFFFFFFFC);
    chk32("imm_wdata", WriteDataE, 32'hAAAA0000);
    chk32("imm_pctarget", PCTargetE, 32'd0);

    // Random loads covering every ALUControl encoding
    for (int i = 0; i < 8; i++) begin
      drive_rand_d();
      ALUControlD = 3'(i);
      ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
      ALUResultM = $urandom; ResultW = $urandom;
      step($sformatf("rand_load_%0d", i));
      chk32($sformatf("aluctl_pass_%0d", i), {29'd0, ALUControlE}, 32'(i));
    end

    // Stall for three edges with changing D inputs
    held_pc = PCE;
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand_d();
      step($sformatf("stall_%0d", i));
    end
    chk32("stall_pc_held", PCE, held_pc);

    // Flush while stalled
    bc_before = BubbleCount;
    FlushE = 1'b1; drive_rand_d();
    step("stall_flush");
    chk32("flush_rd", {27'd0, RdE}, 32'd0);
    chk32("flush_valid", {31'd0, ValidE}, 32'd0);
    chk32("flush_bc", {16'd0, BubbleCount}, {16'd0, bc_before + 16'd1});
    FlushE = 1'b0; StallE = 1'b0;

    // Load, stall, then reset while stalled
    drive_rand_d();
    step("pre_stall_load");
    StallE = 1'b1; drive_rand_d();
    step("stall_hold");
    rst_n = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    step("reset_mid_stall");
    chk_all_zero("reset_mid_stall_zero");
    rst_n = 1'b1; StallE = 1'b0; drive_rand_d();
    step("resume_after_reset");
    chk32("resume_valid", {31'd0, ValidE}, 32'd1);

    // Run the bubble counter up to FFFE
    FlushE = 1'b1;
    guard = 0;
    while (m_bc != 16'hFFFE && guard < 70000) begin
      model_edge();
      @(posedge clk);
      guard++;
    end
    #1;
    chk32("bc_preset", {16'd0, BubbleCount}, 32'h0000FFFE);

    // Three more flushes: saturates
    for (int i = 0; i < 3; i++) begin
      drive_rand_d();
      step($sformatf("sat_flush_%0d", i));
    end
    chk32("bc_saturated", {16'd0, BubbleCount}, 32'h0000FFFF);

    // Reset clears the counter and everything else
    FlushE = 1'b0; rst_n = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    step("final_reset");
    chk32("final_bc", {16'd0, BubbleCount}, 32'd0);
    chk_all_zero("final_zero");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
